idli_sqi_ctrl_m: RTL and testbench

// Parametrised SQI memory controller. Drives NUM_MEM nibble-sliced SQI SRAMs
// in lock-step: shared SCK/CS, one 4-bit SIO bus per memory. Turns word-level

---
 rtl/idli_sqi_ctrl_m.sv | 241 ++++++++++++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory controller: drives NUM_MEM nibble-sliced SQI SRAMs in lock-step and
// streams sequential same-direction words without re-issuing command and address.
module idli_sqi_ctrl_m #(
   parameter int         NUM_MEM    = 2,
   parameter int         DATA_W     = 16,
   parameter int         ADDR_W     = 16,
   parameter int         MEM_ADDR_W = 24,
   parameter int         DUMMY_CYC  = 2,
   parameter logic [7:0] CMD_RD     = 8'h03,
   parameter logic [7:0] CMD_WR     = 8'h02
) (
   input  logic                   i_sqi_gck,
   input  logic                   i_sqi_rst_n,
   input  logic                   i_sqi_req,
   input  logic                   i_sqi_wr,
   input  logic [ADDR_W-1:0]      i_sqi_addr,
   input  logic [DATA_W-1:0]      i_sqi_wdata,
   input  logic                   i_sqi_redirect,
   output logic                   o_sqi_ack,
   output logic [DATA_W-1:0]      o_sqi_rdata,
   output logic                   o_sqi_busy,
   output logic                   o_sqi_cs,
   output logic                   o_sqi_sck_en,
   output logic                   o_sqi_oe,
   output logic [4*NUM_MEM-1:0]   o_sqi_sio,
   input  logic [4*NUM_MEM-1:0]   i_sqi_sio
);

   localparam int SW       = 4 * NUM_MEM;
   localparam int NPW      = DATA_W / SW;
   localparam int BPW      = DATA_W / (8 * NUM_MEM);
   localparam int ADDR_CYC = MEM_ADDR_W / 4;
   localparam int CNT_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DUMMY = 3'd3,
      ST_DATA  = 3'd4,
      ST_GAP   = 3'd5,
      ST_END   = 3'd6
   } state_t;

   state_t                 state_r, state_nx_s;
   logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
   logic                   dir_r, dir_nx_s;
   logic [ADDR_W-1:0]      addr_r, addr_nx_s;
   logic                   cont_s;
   logic [MEM_ADDR_W-1:0]  maddr_s;
   logic [DATA_W-1:0]      rd_shift_r, rd_nx_s;
   logic [7:0]             op_s;
   logic [3:0]             nib_s;
   int                     aidx_s, didx_s;

   logic                   cs_r, cs_nx_s;
   logic                   sck_en_r, sck_en_nx_s;
   logic                   oe_r, oe_nx_s;
   logic [SW-1:0]          sio_r, sio_nx_s;
   logic                   ack_r;
   logic                   busy_r;
   logic [DATA_W-1:0]      rdata_r;

   assign maddr_s = MEM_ADDR_W'(addr_r) * MEM_ADDR_W'(BPW);
   assign rd_nx_s = (rd_shift_r << SW) | DATA_W'(i_sqi_sio);
   assign cont_s  = i_sqi_req && (i_sqi_wr == dir_r) && (i_sqi_addr == addr_r + ADDR_W'(1));

   // Next-state, step counter and transfer context (direction, word address)
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = CNT_W'(0);
      dir_nx_s   = dir_r;
      addr_nx_s  = addr_r;
      if (i_sqi_redirect && (state_r != ST_IDLE)) begin
         state_nx_s = ST_END;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_sqi_req && !i_sqi_redirect) begin
                  state_nx_s = ST_CMD;
                  dir_nx_s   = i_sqi_wr;
                  addr_nx_s  = i_sqi_addr;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_CMD: begin
               if (cnt_r == CNT_W'(1)) begin
                  state_nx_s = ST_ADDR;
               end else begin
                  cnt_nx_s = cnt_r + CNT_W'(1);
               end
            end
            ST_ADDR: begin
               if (cnt_r == CNT_W'(ADDR_CYC - 1)) begin
                  if (!dir_r && (DUMMY_CYC > 0)) begin
                     state_nx_s = ST_DUMMY;
                  end else begin
                     state_nx_s = ST_DATA;
                  end
               end else begin
                  cnt_nx_s = cnt_r + CNT_W'(1);
               end
            end
            ST_DUMMY: begin
               if (cnt_r == CNT_W'(DUMMY_CYC - 1)) begin
                  state_nx_s = ST_DATA;
               end else begin
                  cnt_nx_s = cnt_r + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt_r == CNT_W'(NPW - 1)) begin
                  state_nx_s = ST_GAP;
               end else begin
                  cnt_nx_s = cnt_r + CNT_W'(1);
               end
            end
            ST_GAP: begin
               // A matching follow-on request keeps CS low and skips straight to data
               if (cont_s) begin
                  state_nx_s = ST_DATA;
                  addr_nx_s  = i_sqi_addr;
               end else begin
                  state_nx_s = ST_END;
               end
            end
            ST_END:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // Pad values for the coming cycle, derived from the next state so they can be registered
   always_comb begin
      cs_nx_s     = 1'b1;
      sck_en_nx_s = 1'b0;
      oe_nx_s     = 1'b0;
      sio_nx_s    = SW'(0);
      op_s        = dir_nx_s ? CMD_WR : CMD_RD;
      nib_s       = 4'h0;
      aidx_s      = ADDR_CYC - 1 - int'(cnt_nx_s);
      didx_s      = NPW - 1 - int'(cnt_nx_s);
      case (state_nx_s)
         ST_CMD: begin
            cs_nx_s     = 1'b0;
            sck_en_nx_s = 1'b1;
            oe_nx_s     = 1'b1;
            if (cnt_nx_s[0]) begin
               nib_s = op_s[3:0];
            end else begin
               nib_s = op_s[7:4];
            end
            sio_nx_s = {NUM_MEM{nib_s}};
         end
         ST_ADDR: begin
            cs_nx_s     = 1'b0;
            sck_en_nx_s = 1'b1;
            oe_nx_s     = 1'b1;
            nib_s       = maddr_s[4*aidx_s +: 4];
            sio_nx_s    = {NUM_MEM{nib_s}};
         end
         ST_DUMMY: begin
            cs_nx_s     = 1'b0;
            sck_en_nx_s = 1'b1;
         end
         ST_DATA: begin
            cs_nx_s     = 1'b0;
            sck_en_nx_s = 1'b1;
            oe_nx_s     = dir_nx_s;
            if (dir_nx_s) begin
               sio_nx_s = i_sqi_wdata[SW*didx_s +: SW];
            end else begin
               sio_nx_s = SW'(0);
            end
         end
         ST_GAP:  cs_nx_s = 1'b0;
         default: cs_nx_s = 1'b1;
      endcase
   end

   // State register and transfer context
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_W'(0);
         dir_r   <= 1'b0;
         addr_r  <= ADDR_W'(0);
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         dir_r   <= dir_nx_s;
         addr_r  <= addr_nx_s;
      end
   end

   // Read assembly: each data step shifts in one nibble per memory, first step ends up on top
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         rd_shift_r <= DATA_W'(0);
      end else if ((state_r == ST_DATA) && !dir_r) begin
         rd_shift_r <= rd_nx_s;
      end else begin
         rd_shift_r <= rd_shift_r;
      end
   end

   // Registered pad and core-side outputs
   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         cs_r     <= 1'b1;
         sck_en_r <= 1'b0;
         oe_r     <= 1'b0;
         sio_r    <= SW'(0);
         ack_r    <= 1'b0;
         busy_r   <= 1'b0;
         rdata_r  <= DATA_W'(0);
      end else begin
         cs_r     <= cs_nx_s;
         sck_en_r <= sck_en_nx_s;
         oe_r     <= oe_nx_s;
         sio_r    <= sio_nx_s;
         ack_r    <= (state_nx_s == ST_GAP);
         busy_r   <= (state_nx_s != ST_IDLE);
         if ((state_r == ST_DATA) && (state_nx_s == ST_GAP) && !dir_r) begin
            rdata_r <= rd_nx_s;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   assign o_sqi_cs     = cs_r;
   assign o_sqi_sck_en = sck_en_r;
   assign o_sqi_oe     = oe_r;
   assign o_sqi_sio    = sio_r;
   assign o_sqi_ack    = ack_r;
   assign o_sqi_busy   = busy_r;
   assign o_sqi_rdata  = rdata_r;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: table of single-word transfers plus hand-written
// streaming, redirect, reset and wide-configuration sequences.
module tb_idli_sqi_ctrl_m;

   logic        clk;
   logic        rst_n;
   logic        req, wr, redirect;
   logic [15:0] addr, wdata;
   logic        ack, busy, cs, sck_en, oe;
   logic [15:0] rdata;
   logic [7:0]  sio_o, sio_i;

   logic        req2, wr2, redirect2;
   logic [15:0] addr2;
   logic [31:0] wdata2;
   logic        ack2, busy2, cs2, sck2, oe2;
   logic [31:0] rdata2;
   logic [15:0] sio2_o, sio2_i;

   idli_sqi_ctrl_m dut (
      .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req(req), .i_sqi_wr(wr),
      .i_sqi_addr(addr), .i_sqi_wdata(wdata), .i_sqi_redirect(redirect),
      .o_sqi_ack(ack), .o_sqi_rdata(rdata), .o_sqi_busy(busy), .o_sqi_cs(cs),
      .o_sqi_sck_en(sck_en), .o_sqi_oe(oe), .o_sqi_sio(sio_o), .i_sqi_sio(sio_i)
   );

   idli_sqi_ctrl_m #(.NUM_MEM(4), .DATA_W(32)) dut2 (
      .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_req(req2), .i_sqi_wr(wr2),
      .i_sqi_addr(addr2), .i_sqi_wdata(wdata2), .i_sqi_redirect(redirect2),
      .o_sqi_ack(ack2), .o_sqi_rdata(rdata2), .o_sqi_busy(busy2), .o_sqi_cs(cs2),
      .o_sqi_sck_en(sck2), .o_sqi_oe(oe2), .o_sqi_sio(sio2_o), .i_sqi_sio(sio2_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [7:0]  rd0, rd1;
      int          ack_rel;
      logic [15:0] rdata;
      int          slen;
      logic [79:0] stream;
   } vec_t;

   vec_t        vecs [4];
   int          n_checks, n_errors;
   int          cyc, t0, rel, cs_falls, dummy_left, k, got_rel;
   logic        prev_cs, ok, done;
   logic        cs_hist [0:63];
   logic [7:0]  memq [$];
   logic [7:0]  stream_q [$];
   int          ack_rel_q [$];
   logic [15:0] ack_dat_q [$];
   logic        w_wr [4];
   logic [15:0] w_addr [4];
   logic [15:0] w_wdata [4];
   logic [79:0] got_s;
   logic [3:0]  exp_n;
   logic [31:0] got_d2;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one cycle, record DUT activity and play the SQI memory side
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      rel = cyc - t0;
      if (rel >= 0 && rel < 64) cs_hist[rel] = cs;
      if (ack) begin
         ack_rel_q.push_back(rel);
         ack_dat_q.push_back(rdata);
      end
      if (prev_cs && !cs) cs_falls++;
      prev_cs = cs;
      sio_i = 8'h00;
      if (sck_en && oe) begin
         stream_q.push_back(sio_o);
         dummy_left = 2;
      end else if (sck_en && !oe) begin
         if (dummy_left > 0) begin
            dummy_left--;
            sio_i = 8'hE7;
         end else if (memq.size() > 0) begin
            sio_i = memq.pop_front();
         end
      end
   endtask

   task automatic clear_rec();
      ack_rel_q.delete();
      ack_dat_q.delete();
      stream_q.delete();
      cs_falls = 0;
      prev_cs = cs;
      for (int i = 0; i < 64; i++) cs_hist[i] = 1'bx;
      t0 = cyc;
   endtask

   task automatic apply_word(input int i);
      wr = w_wr[i];
      addr = w_addr[i];
      wdata = w_wdata[i];
      req = 1'b1;
   endtask

   // Issue n words back to back, presenting each next word in the ack cycle
   task automatic run_words(input int n);
      clear_rec();
      k = 0;
      done = 1'b0;
      apply_word(0);
      for (int c = 0; c < 100 && !done; c++) begin
         tick();
         if (ack) begin
            k++;
            if (k < n) apply_word(k);
            else req = 1'b0;
         end
         if (k >= n && !busy) done = 1'b1;
      end
      req = 1'b0;
      check("run_complete", done, 1'b1);
   endtask

   task automatic run_redir(input logic [15:0] a, input int at, input logic nxt, input int exp_acks);
      clear_rec();
      wr = 1'b0;
      addr = a;
      req = 1'b1;
      for (int r = 1; r <= 20; r++) begin
         tick();
         if (r == at) begin
            redirect = 1'b1;
            if (nxt) addr = a + 16'd1;
            else req = 1'b0;
         end else if (r == at + 1) begin
            redirect = 1'b0;
            req = 1'b0;
            check("redir_cs", cs, 1'b1);
            check("redir_sck", sck_en, 1'b0);
            check("redir_oe", oe, 1'b0);
            check("redir_busy_end", busy, 1'b1);
         end else if (r == at + 2) begin
            check("redir_busy_idle", busy, 1'b0);
         end
      end
      check("redir_ack_count", ack_rel_q.size(), exp_acks);
   endtask

   initial begin
      n_checks = 0; n_errors = 0; cyc = 0; t0 = 0; dummy_left = 0;
      rst_n = 1'b0; req = 1'b0; wr = 1'b0; redirect = 1'b0;
      addr = 16'h0; wdata = 16'h0; sio_i = 8'h0;
      req2 = 1'b0; wr2 = 1'b0; redirect2 = 1'b0; addr2 = 16'h0; wdata2 = 32'h0; sio2_i = 16'h0;

      vecs[0] = '{1'b0, 16'h0012, 16'h0000, 8'hBA, 8'hDC, 13, 16'hBADC, 8,
                  {8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00}};
      vecs[1] = '{1'b1, 16'h0100, 16'h1234, 8'h00, 8'h00, 11, 16'hBADC, 10,
                  {8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h12, 8'h34}};
      vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 8'h5A, 8'hC3, 13, 16'h5AC3, 8,
                  {8'h00, 8'h33, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}};
      vecs[3] = '{1'b1, 16'hABCD, 16'hBEEF, 8'h00, 8'h00, 11, 16'h5AC3, 10,
                  {8'h00, 8'h22, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hBE, 8'hEF}};

      #12;
      check("rst_cs", cs, 1'b1);
      check("rst_sck", sck_en, 1'b0);
      check("rst_oe", oe, 1'b0);
      check("rst_sio", sio_o, 8'h00);
      check("rst_ack", ack, 1'b0);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_busy", busy, 1'b0);
      #10 rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 4; i++) begin
         memq = '{vecs[i].rd0, vecs[i].rd1};
         w_wr[0] = vecs[i].wr; w_addr[0] = vecs[i].addr; w_wdata[0] = vecs[i].wdata;
         run_words(1);
         check("vec_ack_count", ack_rel_q.size(), 1);
         if (ack_rel_q.size() > 0) begin
            check("vec_ack_cycle", ack_rel_q[0], vecs[i].ack_rel);
            check("vec_rdata", ack_dat_q[0], vecs[i].rdata);
         end
         check("vec_stream_len", stream_q.size(), vecs[i].slen);
         got_s = 80'h0;
         for (int j = 0; j < stream_q.size() && j < 10; j++) got_s[79-8*j -: 8] = stream_q[j];
         check("vec_stream", got_s, vecs[i].stream);
         ok = 1'b1;
         for (int r = 1; r <= vecs[i].ack_rel; r++) if (cs_hist[r] !== 1'b0) ok = 1'b0;
         if (cs_hist[vecs[i].ack_rel + 1] !== 1'b1) ok = 1'b0;
         check("vec_cs_window", ok, 1'b1);
         tick();
      end

      // Streaming reads
      memq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      w_wr[0] = 1'b0; w_addr[0] = 16'h0010;
      w_wr[1] = 1'b0; w_addr[1] = 16'h0011;
      w_wr[2] = 1'b0; w_addr[2] = 16'h0012;
      run_words(3);
      check("stream_ack_count", ack_rel_q.size(), 3);
      if (ack_rel_q.size() == 3) begin
         check("stream_ack_cycles", {ack_rel_q[0], ack_rel_q[1], ack_rel_q[2]}, {32'd13, 32'd16, 32'd19});
         check("stream_rdata", {ack_dat_q[0], ack_dat_q[1], ack_dat_q[2]}, {16'h1122, 16'h3344, 16'h5566});
      end
      check("stream_cs_falls", cs_falls, 1);
      check("stream_cmd_addr_len", stream_q.size(), 8);
      ok = 1'b1;
      for (int r = 1; r <= 19; r++) if (cs_hist[r] !== 1'b0) ok = 1'b0;
      check("stream_cs_low", ok, 1'b1);
      tick();

      // Direction change breaks the stream
      memq = '{8'hAB, 8'hCD};
      w_wr[0] = 1'b0; w_addr[0] = 16'h0010;
      w_wr[1] = 1'b1; w_addr[1] = 16'h0011; w_wdata[1] = 16'h0F0F;
      run_words(2);
      check("dirbrk_ack_count", ack_rel_q.size(), 2);
      if (ack_rel_q.size() == 2) begin
         check("dirbrk_ack_cycles", {ack_rel_q[0], ack_rel_q[1]}, {32'd13, 32'd26});
         check("dirbrk_rdata", ack_dat_q[0], 16'hABCD);
      end
      check("dirbrk_cs_falls", cs_falls, 2);
      tick();

      // Non-sequential address breaks the stream
      memq = '{8'h01, 8'h02, 8'h03, 8'h04};
      w_wr[0] = 1'b0; w_addr[0] = 16'h0010;
      w_wr[1] = 1'b0; w_addr[1] = 16'h0020;
      run_words(2);
      if (ack_rel_q.size() == 2) begin
         check("adrbrk_ack_cycles", {ack_rel_q[0], ack_rel_q[1]}, {32'd13, 32'd28});
         check("adrbrk_rdata", {ack_dat_q[0], ack_dat_q[1]}, {16'h0102, 16'h0304});
      end else begin
         check("adrbrk_ack_count", ack_rel_q.size(), 2);
      end
      check("adrbrk_cs_falls", cs_falls, 2);
      tick();

      // Address wrap still streams
      memq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      w_wr[0] = 1'b0; w_addr[0] = 16'hFFFF;
      w_wr[1] = 1'b0; w_addr[1] = 16'h0000;
      run_words(2);
      if (ack_rel_q.size() == 2) begin
         check("wrap_ack_cycles", {ack_rel_q[0], ack_rel_q[1]}, {32'd13, 32'd16});
         check("wrap_rdata", {ack_dat_q[0], ack_dat_q[1]}, {16'hAABB, 16'hCCDD});
      end else begin
         check("wrap_ack_count", ack_rel_q.size(), 2);
      end
      check("wrap_cs_falls", cs_falls, 1);
      tick();

      // Redirects: in ADDR, in read DATA step 0, and in GAP with a streamable follow-on
      memq.delete();
      run_redir(16'h0040, 4, 1'b0, 0);
      tick();
      memq = '{8'h99, 8'h88};
      run_redir(16'h0050, 11, 1'b0, 0);
      check("redir_rdata_hold", rdata, 16'hCCDD);
      tick();
      memq = '{8'h12, 8'h34};
      run_redir(16'h0010, 13, 1'b1, 1);
      if (ack_dat_q.size() == 1) begin
         check("redir_gap_ack_cycle", ack_rel_q[0], 13);
         check("redir_gap_rdata", ack_dat_q[0], 16'h1234);
      end
      tick();

      // Reset during write data
      clear_rec();
      wr = 1'b1; addr = 16'h0002; wdata = 16'h9A5C; req = 1'b1;
      repeat (9) tick();
      check("pre_rst_sio", sio_o, 8'h9A);
      check("pre_rst_oe", oe, 1'b1);
      #2;
      rst_n = 1'b0;
      req = 1'b0;
      #1;
      check("midrst_cs", cs, 1'b1);
      check("midrst_sck", sck_en, 1'b0);
      check("midrst_oe", oe, 1'b0);
      check("midrst_sio", sio_o, 8'h00);
      check("midrst_ack", ack, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_rdata", rdata, 16'h0000);
      #2 rst_n = 1'b1;
      repeat (2) tick();
      check("postrst_idle", {cs, busy}, {1'b1, 1'b0});

      // Four memories, 32-bit word
      clear_rec();
      addr2 = 16'h0001; req2 = 1'b1; ok = 1'b1; got_rel = -1; got_d2 = 32'h0;
      for (int r = 1; r <= 20; r++) begin
         tick();
         sio2_i = 16'h0000;
         if (r >= 3 && r <= 8) begin
            exp_n = (r == 8) ? 4'h1 : 4'h0;
            if (sio2_o !== {4{exp_n}} || oe2 !== 1'b1) ok = 1'b0;
         end
         if (r == 11) sio2_i = 16'h4321;
         if (r == 12) sio2_i = 16'h8765;
         if (ack2) begin
            got_rel = r;
            got_d2 = rdata2;
            req2 = 1'b0;
         end
      end
      check("wide_addr_field", ok, 1'b1);
      check("wide_ack_cycle", got_rel, 13);
      check("wide_rdata", got_d2, 32'h4321_8765);
      check("wide_idle", busy2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
